coef_loader: RTL and testbench

COEF_LOADER -- requirements
Module: coef_loader

---
 rtl/coef_loader_pkg.sv | 18 +
 rtl/byte_packer.sv | 54 +++++
 rtl/coef_loader.sv | 143 ++++++++++++++
 tb/tb_coef_loader.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/coef_loader_pkg.sv
// coef_loader_pkg
//   Shared definitions for the coefficient loader:
//   - default widths for the RAM write port and the byte packing ratio
//   - FSM state encoding used by coef_loader
package coef_loader_pkg;

  localparam int ADDR_W_DEFAULT         = 14;
  localparam int DATA_W_DEFAULT         = 36;
  localparam int BYTES_PER_WORD_DEFAULT = 5;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    WRITE   = 2'd2,
    FINISH  = 2'd3
  } state_t;

endpackage

// File: rtl/byte_packer.sv
// byte_packer
//   Assembles BYTES_PER_WORD bytes, MSB first, into one DATA_W-bit word.
//   Bytes are shifted in from the bottom; bits shifted past the top of the
//   word are dropped, which is how the upper nibble of the first byte of a
//   36-bit word disappears.
// Ports
//   clk        : clock, posedge
//   rst_n      : asynchronous active-low reset
//   clear      : synchronous restart of the byte counter (new load)
//   byte_en    : a byte is accepted this cycle
//   byte_in    : byte being accepted
//   word_valid : the byte accepted this cycle completes a word
//   word_out   : assembled word (holds the completed word from the next cycle)
module byte_packer
  import coef_loader_pkg::*;
#(
  parameter int DATA_W         = DATA_W_DEFAULT,
  parameter int BYTES_PER_WORD = BYTES_PER_WORD_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              byte_en,
  input  logic [7:0]        byte_in,
  output logic              word_valid,
  output logic [DATA_W-1:0] word_out
);

  localparam int CNT_W = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BYTES_PER_WORD - 1);

  logic [CNT_W-1:0]  cnt_reg;
  logic [DATA_W-1:0] word_reg;
  logic [DATA_W-1:0] word_next;

  // Shift the new byte in at the bottom; the cast keeps the low DATA_W bits.
  assign word_next  = DATA_W'({word_reg, byte_in});
  assign word_valid = byte_en && (cnt_reg == LAST_IDX);
  assign word_out   = word_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg  <= '0;
      word_reg <= '0;
    end else if (clear) begin
      cnt_reg  <= '0;
      word_reg <= '0;
    end else if (byte_en) begin
      word_reg <= word_next;
      cnt_reg  <= (cnt_reg == LAST_IDX) ? '0 : cnt_reg + 1'b1;
    end
  end

endmodule

// File: rtl/coef_loader.sv
// coef_loader
//   Loads a block of coefficient words from a byte stream into the left or
//   right coefficient RAM bank. A load is requested with load_start, which
//   captures the bank, first address and word count. Each group of
//   BYTES_PER_WORD bytes becomes one word, written with a single-cycle
//   strobe on weL or weR; the address increments (wrapping) after each
//   write. done pulses for one cycle at the end of the load.
// Ports
//   clockext100MHz : clock, posedge
//   reset          : asynchronous active-low reset
//   load_start     : load request (ignored and flagged while busy)
//   sel_right      : target bank, 0 = left, 1 = right
//   start_addr     : first write address
//   num_words      : number of words to load (0 completes immediately)
//   byte_in/byte_valid/byte_ready : byte stream handshake
//   addr_wr/data_wr/weL/weR       : RAM write port
//   busy, done, start_ignored     : status
module coef_loader
  import coef_loader_pkg::*;
#(
  parameter int ADDR_W         = ADDR_W_DEFAULT,
  parameter int DATA_W         = DATA_W_DEFAULT,
  parameter int BYTES_PER_WORD = BYTES_PER_WORD_DEFAULT
) (
  input  logic              clockext100MHz,
  input  logic              reset,
  input  logic              load_start,
  input  logic              sel_right,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W:0]   num_words,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic [ADDR_W-1:0] addr_wr,
  output logic [DATA_W-1:0] data_wr,
  output logic              weL,
  output logic              weR,
  output logic              busy,
  output logic              done,
  output logic              start_ignored
);

  state_t              state_reg, state_next;
  logic                sel_reg, sel_next;
  logic [ADDR_W-1:0]   addr_reg, addr_next;
  logic [ADDR_W:0]     remain_reg, remain_next;
  logic                ign_reg, ign_next;

  logic                start_accept;
  logic                byte_accept;
  logic                word_valid;
  logic [DATA_W-1:0]   word_out;
  logic [1:0]          bank_we;

  assign start_accept = load_start && (state_reg == IDLE);
  assign byte_ready   = (state_reg == COLLECT);
  assign byte_accept  = byte_valid && byte_ready;

  byte_packer #(
    .DATA_W        (DATA_W),
    .BYTES_PER_WORD(BYTES_PER_WORD)
  ) u_packer (
    .clk       (clockext100MHz),
    .rst_n     (reset),
    .clear     (start_accept),
    .byte_en   (byte_accept),
    .byte_in   (byte_in),
    .word_valid(word_valid),
    .word_out  (word_out)
  );

  always_ff @(posedge clockext100MHz or negedge reset) begin
    if (!reset) begin
      state_reg  <= IDLE;
      sel_reg    <= 1'b0;
      addr_reg   <= '0;
      remain_reg <= '0;
      ign_reg    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      sel_reg    <= sel_next;
      addr_reg   <= addr_next;
      remain_reg <= remain_next;
      ign_reg    <= ign_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    sel_next    = sel_reg;
    addr_next   = addr_reg;
    remain_next = remain_reg;
    ign_next    = ign_reg;

    case (state_reg)
      IDLE: begin
        if (load_start) begin
          sel_next    = sel_right;
          addr_next   = start_addr;
          remain_next = num_words;
          ign_next    = 1'b0;
          state_next  = (num_words == '0) ? FINISH : COLLECT;
        end
      end
      COLLECT: begin
        // The last byte of a word moves us to WRITE on the same edge that
        // latches it into the packer, so data is ready in WRITE.
        if (word_valid) begin
          state_next = WRITE;
        end
      end
      WRITE: begin
        addr_next   = addr_reg + 1'b1;
        remain_next = remain_reg - 1'b1;
        state_next  = (remain_reg == (ADDR_W+1)'(1)) ? FINISH : COLLECT;
      end
      FINISH: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    if (load_start && (state_reg != IDLE)) begin
      ign_next = 1'b1;
    end
  end

  // One strobe per bank; sel_reg picks exactly one, so both never fire.
  for (genvar gi = 0; gi < 2; gi++) begin : g_bank_we
    assign bank_we[gi] = (state_reg == WRITE) && (sel_reg == 1'(gi));
  end

  assign weL           = bank_we[0];
  assign weR           = bank_we[1];
  assign addr_wr       = addr_reg;
  assign data_wr       = word_out;
  assign busy          = (state_reg != IDLE);
  assign done          = (state_reg == FINISH);
  assign start_ignored = ign_reg;

endmodule

// File: tb/tb_coef_loader.sv
module tb_coef_loader;

  localparam int AW = 14;
  localparam int DW = 36;

  logic          clk;
  logic          reset;
  logic          load_start;
  logic          sel_right;
  logic [AW-1:0] start_addr;
  logic [AW:0]   num_words;
  logic [7:0]    byte_in;
  logic          byte_valid;
  logic          byte_ready;
  logic [AW-1:0] addr_wr;
  logic [DW-1:0] data_wr;
  logic          weL;
  logic          weR;
  logic          busy;
  logic          done;
  logic          start_ignored;

  coef_loader #(
    .ADDR_W        (AW),
    .DATA_W        (DW),
    .BYTES_PER_WORD(5)
  ) dut (
    .clockext100MHz(clk),
    .reset         (reset),
    .load_start    (load_start),
    .sel_right     (sel_right),
    .start_addr    (start_addr),
    .num_words     (num_words),
    .byte_in       (byte_in),
    .byte_valid    (byte_valid),
    .byte_ready    (byte_ready),
    .addr_wr       (addr_wr),
    .data_wr       (data_wr),
    .weL           (weL),
    .weR           (weR),
    .busy          (busy),
    .done          (done),
    .start_ignored (start_ignored)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Write monitor: logs every write strobe and done pulse.
  logic [AW-1:0] mon_addr [$];
  logic [DW-1:0] mon_data [$];
  bit            mon_sel  [$];
  int            done_total = 0;
  bit            both_seen  = 0;

  always @(negedge clk) begin
    if (weL || weR) begin
      mon_addr.push_back(addr_wr);
      mon_data.push_back(data_wr);
      mon_sel.push_back(weR);
    end
    if (weL && weR) both_seen = 1;
    if (done) done_total++;
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    bit            sel;
    logic [AW-1:0] addr;
    int            n;
    bit            toggle;
    logic [79:0]   bytes;
    logic [AW-1:0] ea0;
    logic [DW-1:0] ed0;
    logic [AW-1:0] ea1;
    logic [DW-1:0] ed1;
  } vec_t;

  vec_t        vecs [4];
  logic [79:0] cur_bytes;

  task automatic start_load(input bit s, input logic [AW-1:0] a, input int n);
    @(negedge clk);
    load_start = 1'b1;
    sel_right  = s;
    start_addr = a;
    num_words  = (AW+1)'(n);
    @(negedge clk);
    load_start = 1'b0;
  endtask

  // Feeds n bytes from cur_bytes; optionally idles every other cycle and
  // optionally fires a conflicting load_start when byte index inj_at is offered.
  task automatic feed(input int n, input bit toggle, input int inj_at);
    int  idx = 0;
    int  cyc = 0;
    bit  phase = 0;
    bit  injected = 0;
    while (idx < n && cyc < 300) begin
      @(negedge clk);
      cyc++;
      load_start = 1'b0;
      if (toggle && phase) begin
        byte_valid = 1'b0;
      end else begin
        byte_valid = 1'b1;
        byte_in    = cur_bytes[79 - 8*idx -: 8];
      end
      phase = !phase;
      if (inj_at >= 0 && idx == inj_at && !injected) begin
        load_start = 1'b1;
        sel_right  = 1'b1;
        start_addr = AW'(50);
        num_words  = (AW+1)'(3);
        injected   = 1;
      end
      if (byte_valid && byte_ready) idx++;
    end
    @(negedge clk);
    byte_valid = 1'b0;
    load_start = 1'b0;
    chk("feed_complete", 64'(idx), 64'(n));
  endtask

  task automatic wait_done();
    int c = 0;
    while (!done && c < 50) begin
      @(negedge clk);
      c++;
    end
    chk("done_seen", 64'(done), 64'd1);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int w0;
    int d0;

    reset      = 1'b0;
    load_start = 1'b0;
    sel_right  = 1'b0;
    start_addr = '0;
    num_words  = '0;
    byte_in    = 8'h00;
    byte_valid = 1'b0;

    vecs[0] = '{sel:1'b0, addr:14'd0, n:2, toggle:1'b0, bytes:80'h0A12345678_0102030405,
                ea0:14'd0, ed0:36'hA12345678, ea1:14'd1, ed1:36'h102030405};
    vecs[1] = '{sel:1'b1, addr:14'd16383, n:2, toggle:1'b0, bytes:80'hFFFFFFFFFF_F300000001,
                ea0:14'd16383, ed0:36'hFFFFFFFFF, ea1:14'd0, ed1:36'h300000001};
    vecs[2] = '{sel:1'b0, addr:14'd0, n:2, toggle:1'b1, bytes:80'h0A12345678_0102030405,
                ea0:14'd0, ed0:36'hA12345678, ea1:14'd1, ed1:36'h102030405};
    vecs[3] = '{sel:1'b0, addr:14'd100, n:1, toggle:1'b0, bytes:80'h5BAABBCCDD_0000000000,
                ea0:14'd100, ed0:36'hBAABBCCDD, ea1:14'd0, ed1:36'h0};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_ready", 64'(byte_ready), 64'd0);
    chk("rst_we", 64'({weL, weR}), 64'd0);
    chk("rst_addr", 64'(addr_wr), 64'd0);
    chk("rst_data", 64'(data_wr), 64'd0);
    chk("rst_ign", 64'(start_ignored), 64'd0);
    reset = 1'b1;

    // byte_valid in IDLE is ignored
    @(negedge clk);
    byte_valid = 1'b1;
    byte_in    = 8'hAB;
    repeat (3) @(negedge clk);
    chk("idle_valid_busy", 64'(busy), 64'd0);
    chk("idle_valid_ready", 64'(byte_ready), 64'd0);
    byte_valid = 1'b0;

    // Table-driven loads
    for (int i = 0; i < 4; i++) begin
      w0 = mon_addr.size();
      d0 = done_total;
      start_load(vecs[i].sel, vecs[i].addr, vecs[i].n);
      cur_bytes = vecs[i].bytes;
      feed(vecs[i].n * 5, vecs[i].toggle, -1);
      wait_done();
      chk($sformatf("v%0d_nwrites", i), 64'(mon_addr.size() - w0), 64'(vecs[i].n));
      for (int k = 0; k < vecs[i].n && (w0 + k) < mon_addr.size(); k++) begin
        chk($sformatf("v%0d_w%0d_addr", i, k), 64'(mon_addr[w0+k]),
            64'((k == 0) ? vecs[i].ea0 : vecs[i].ea1));
        chk($sformatf("v%0d_w%0d_data", i, k), 64'(mon_data[w0+k]),
            64'((k == 0) ? vecs[i].ed0 : vecs[i].ed1));
        chk($sformatf("v%0d_w%0d_bank", i, k), 64'(mon_sel[w0+k]), 64'(vecs[i].sel));
      end
      chk($sformatf("v%0d_ndone", i), 64'(done_total - d0), 64'd1);
      $display("load %0d: bank=%0d addr=%0d words=%0d writes=%0d", i, vecs[i].sel,
               vecs[i].addr, vecs[i].n, mon_addr.size() - w0);
    end

    // load_start while busy: ignored, flagged, original load unchanged
    w0 = mon_addr.size();
    d0 = done_total;
    start_load(1'b0, 14'd10, 1);
    cur_bytes = 80'h0FEDCBA987_0000000000;
    feed(5, 1'b0, 2);
    wait_done();
    chk("ign_flag", 64'(start_ignored), 64'd1);
    chk("ign_nwrites", 64'(mon_addr.size() - w0), 64'd1);
    if (mon_addr.size() > w0) begin
      chk("ign_addr", 64'(mon_addr[w0]), 64'd10);
      chk("ign_data", 64'(mon_data[w0]), 64'hFEDCBA987);
      chk("ign_bank", 64'(mon_sel[w0]), 64'd0);
    end
    chk("ign_ndone", 64'(done_total - d0), 64'd1);
    $display("load ignore: writes=%0d start_ignored=%0d", mon_addr.size() - w0, start_ignored);

    // num_words = 0: done the cycle after load_start, no strobes, flag cleared
    w0 = mon_addr.size();
    start_load(1'b1, 14'd5, 0);
    chk("zero_done", 64'(done), 64'd1);
    chk("zero_ready", 64'(byte_ready), 64'd0);
    chk("zero_ign_clr", 64'(start_ignored), 64'd0);
    @(negedge clk);
    chk("zero_done_end", 64'(done), 64'd0);
    chk("zero_idle", 64'(busy), 64'd0);
    chk("zero_nwrites", 64'(mon_addr.size() - w0), 64'd0);
    $display("load zero: done pulse seen, writes=%0d", mon_addr.size() - w0);

    // Reset mid-load after 3 bytes
    w0 = mon_addr.size();
    d0 = done_total;
    start_load(1'b0, 14'd20, 2);
    cur_bytes = 80'h0A12345678_0000000000;
    feed(3, 1'b0, -1);
    #2;
    reset = 1'b0;
    #1;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_ready", 64'(byte_ready), 64'd0);
    chk("abort_addr", 64'(addr_wr), 64'd0);
    chk("abort_data", 64'(data_wr), 64'd0);
    chk("abort_we", 64'({weL, weR}), 64'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (10) @(negedge clk);
    chk("abort_nwrites", 64'(mon_addr.size() - w0), 64'd0);
    chk("abort_ndone", 64'(done_total - d0), 64'd0);
    w0 = mon_addr.size();
    start_load(1'b1, 14'd7, 1);
    cur_bytes = 80'h0123456789_0000000000;
    feed(5, 1'b0, -1);
    wait_done();
    chk("after_abort_nwrites", 64'(mon_addr.size() - w0), 64'd1);
    if (mon_addr.size() > w0) begin
      chk("after_abort_addr", 64'(mon_addr[w0]), 64'd7);
      chk("after_abort_data", 64'(mon_data[w0]), 64'h123456789);
      chk("after_abort_bank", 64'(mon_sel[w0]), 64'd1);
    end
    $display("load after reset: writes=%0d", mon_addr.size() - w0);

    chk("we_exclusive", 64'(both_seen), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
